// File: rtl/program_loader_if.sv
// Loader-side bus for program_loader: command, byte stream, memory write port and status.
// The loader takes the slave modport; the boot host / bench drives the master modport.
interface program_loader_if;
  logic        Start;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemWrite;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [7:0]  Count;

  modport slave (
    input  Start, RxData, RxValid,
    output RxReady, MemAddr, MemData, MemWrite, CpuHold, Done, Error, Count
  );

  modport master (
    output Start, RxData, RxValid,
    input  RxReady, MemAddr, MemData, MemWrite, CpuHold, Done, Error, Count
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: SYNC/LEN/payload[/CHK] byte frames into instruction memory at BASE_ADDR.
// Optional trailing 8-bit additive checksum is enabled by defining LOADER_CSUM_EN.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd10,
  parameter int          MEM_BYTES = 128
) (
  input logic            Clock,
  input logic            ResetN,
  program_loader_if.slave bus
);

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_DATA, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LEN, S_DATA} state_t;
`endif

  state_t      state, state_d;
  logic [7:0]  len, len_d;
  logic [7:0]  cnt, cnt_d;
  logic [15:0] addr, addr_d;
  logic [7:0]  data, data_d;
  logic        wr, wr_d;
  logic        hold, hold_d;
  logic        done, done_d;
  logic        err, err_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]  sum, sum_d;
`endif

  logic        acc;
  logic [7:0]  cnt_inc;
  logic [16:0] end_addr;
  logic        len_bad;

  assign acc      = bus.RxValid && (state != S_IDLE);
  assign cnt_inc  = cnt + 8'd1;
  // One past the last byte the frame would touch; must not exceed the array.
  assign end_addr = {1'b0, BASE_ADDR} + {9'd0, bus.RxData};
  assign len_bad  = (bus.RxData == 8'd0) || bus.RxData[0] || (end_addr > 17'(MEM_BYTES));

  always_comb begin
    state_d = state;
    len_d   = len;
    cnt_d   = cnt;
    addr_d  = addr;
    data_d  = data;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err;
    // Registered one cycle behind state, so hold outlasts the final write.
    hold_d  = (state != S_IDLE);
`ifdef LOADER_CSUM_EN
    sum_d   = sum;
`endif
    case (state)
      S_IDLE: if (bus.Start) begin
        state_d = S_SYNC;
        err_d   = 1'b0;
        cnt_d   = 8'd0;
        hold_d  = 1'b1;
      end
      S_SYNC: if (acc && bus.RxData == 8'hA5) state_d = S_LEN;
      S_LEN: if (acc) begin
        len_d = bus.RxData;
        if (len_bad) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
          cnt_d   = 8'd0;
`ifdef LOADER_CSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_DATA: if (acc) begin
        wr_d   = 1'b1;
        addr_d = BASE_ADDR + {8'd0, cnt};
        data_d = bus.RxData;
        cnt_d  = cnt_inc;
`ifdef LOADER_CSUM_EN
        sum_d  = sum + bus.RxData;
        if (cnt_inc == len) state_d = S_CHK;
`else
        if (cnt_inc == len) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
`endif
      end
`ifdef LOADER_CSUM_EN
      S_CHK: if (acc) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = (bus.RxData != sum);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_IDLE;
      len   <= 8'd0;
      cnt   <= 8'd0;
      addr  <= 16'd0;
      data  <= 8'd0;
      wr    <= 1'b0;
      hold  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum   <= 8'd0;
`endif
    end else begin
      state <= state_d;
      len   <= len_d;
      cnt   <= cnt_d;
      addr  <= addr_d;
      data  <= data_d;
      wr    <= wr_d;
      hold  <= hold_d;
      done  <= done_d;
      err   <= err_d;
`ifdef LOADER_CSUM_EN
      sum   <= sum_d;
`endif
    end
  end

  assign bus.RxReady  = (state != S_IDLE);
  assign bus.MemAddr  = addr;
  assign bus.MemData  = data;
  assign bus.MemWrite = wr;
  assign bus.CpuHold  = hold;
  assign bus.Done     = done;
  assign bus.Error    = err;
  assign bus.Count    = cnt;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes/Done status,
// a negedge monitor pops and compares whenever MemWrite or Done is seen.
module tb_program_loader;
  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  program_loader_if bus ();
  program_loader dut (.Clock(Clock), .ResetN(ResetN), .bus(bus));

  always #5 Clock = ~Clock;

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic err; logic [7:0] cnt; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  wcyc[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge Clock) begin
    wr_t w;
    dn_t d;
    cyc++;
    if (done_prev) chk("cpuhold_fall", 32'(bus.CpuHold), 32'd0);
    done_prev = bus.Done;
    if (bus.MemWrite) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", bus.MemAddr, bus.MemData);
      end else begin
        w = wq.pop_front();
        chk("write_addr", 32'(bus.MemAddr), 32'(w.addr));
        chk("write_data", 32'(bus.MemData), 32'(w.data));
        wcyc.push_back(cyc);
      end
    end
    if (bus.Done) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got Done=1 expected 0");
      end else begin
        d = dq.pop_front();
        chk("done_error", 32'(bus.Error), 32'(d.err));
        chk("done_count", 32'(bus.Count), 32'(d.cnt));
        chk("done_cpuhold", 32'(bus.CpuHold), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic do_start();
    repeat (2) tick();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("start_rxready", 32'(bus.RxReady), 32'd1);
    chk("start_cpuhold", 32'(bus.CpuHold), 32'd1);
    chk("start_error_clr", 32'(bus.Error), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    n = 0;
    while (!bus.RxReady && n < 20) begin tick(); n++; end
    if (n == 20) begin
      checks++; failures++;
      $display("FAIL send_timeout: got RxReady=0 for 20 cycles expected 1 (byte %0h)", b);
    end else tick();
  endtask

  task automatic gap();
    bus.RxValid = 1'b0;
    bus.RxData  = 8'hEE;
    tick();
  endtask

  task automatic run_frame(input logic [7:0] pre[$], input logic [7:0] pl[$],
                           input logic [7:0] chkb, input logic exp_err);
    foreach (pl[i]) wq.push_back(wr_t'{addr: 16'd10 + 16'(i), data: pl[i]});
    dq.push_back(dn_t'{err: exp_err, cnt: 8'(pl.size())});
    do_start();
    foreach (pre[i]) send(pre[i]);
    send(8'hA5);
    send(8'(pl.size()));
    foreach (pl[i]) send(pl[i]);
`ifdef LOADER_CSUM_EN
    send(chkb);
`endif
    // RxValid still high with the last byte: it must not be taken again.
    chk("rxready_after_done", 32'(bus.RxReady), 32'd0);
    gap();
  endtask

  task automatic bad_len(input logic [7:0] n);
    dq.push_back(dn_t'{err: 1'b1, cnt: 8'd0});
    do_start();
    send(8'hA5);
    send(n);
    chk("badlen_rxready", 32'(bus.RxReady), 32'd0);
    chk("badlen_error", 32'(bus.Error), 32'd1);
    bus.RxData = 8'h42;
    repeat (3) tick();
    chk("badlen_rxready_hold", 32'(bus.RxReady), 32'd0);
    chk("badlen_error_sticky", 32'(bus.Error), 32'd1);
    gap();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pre[$];
    logic [7:0] pl[$];
    logic [7:0] s;
    bus.Start = 1'b0; bus.RxData = 8'h00; bus.RxValid = 1'b0;
    ResetN = 1'b0;
    repeat (3) tick();
    chk("rst_rxready",  32'(bus.RxReady),  32'd0);
    chk("rst_memaddr",  32'(bus.MemAddr),  32'd0);
    chk("rst_memdata",  32'(bus.MemData),  32'd0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_cpuhold",  32'(bus.CpuHold),  32'd0);
    chk("rst_done",     32'(bus.Done),     32'd0);
    chk("rst_error",    32'(bus.Error),    32'd0);
    chk("rst_count",    32'(bus.Count),    32'd0);
    ResetN = 1'b1;
    tick();

    // Nominal: 4 back-to-back payload bytes, checksum 0x114 mod 256
    pre.delete();
    pl = '{8'h12, 8'h34, 8'h56, 8'h78};
    wcyc.delete();
    run_frame(pre, pl, 8'h14, 1'b0);
    chk("nominal_count", 32'(bus.Count), 32'd4);
    chk("nominal_error", 32'(bus.Error), 32'd0);
    chk("nominal_consecutive", 32'(wcyc[3] - wcyc[0]), 32'd3);

    // Sync hunt: 00 and FF skipped
    pre = '{8'h00, 8'hFF};
    pl  = '{8'hAB, 8'hCD};
    run_frame(pre, pl, 8'h78, 1'b0);
    chk("hunt_count", 32'(bus.Count), 32'd2);

    // Length errors: odd, zero, past end of memory
    bad_len(8'd3);
    bad_len(8'd0);
    bad_len(8'd120);

`ifdef LOADER_CSUM_EN
    pre.delete();
    pl = '{8'h01, 8'h02};
    run_frame(pre, pl, 8'h00, 1'b1);
    chk("csum_fail_error", 32'(bus.Error), 32'd1);
`endif

    // Largest legal frame fills addresses 10..127
    pre.delete();
    pl.delete();
    s = 8'h00;
    for (int i = 0; i < 118; i++) begin
      pl.push_back(8'(i));
      s = s + 8'(i);
    end
    run_frame(pre, pl, s, 1'b0);
    chk("max_count", 32'(bus.Count), 32'd118);

    // Gapped stream, then reset after first payload byte
    wq.push_back(wr_t'{addr: 16'd10, data: 8'h12});
    do_start();
    send(8'hA5); gap();
    send(8'h04); gap();
    send(8'h12);
    bus.RxValid = 1'b0;
    @(negedge Clock); #1;
    ResetN = 1'b0;
    #1;
    chk("midrst_rxready", 32'(bus.RxReady), 32'd0);
    chk("midrst_memaddr", 32'(bus.MemAddr), 32'd0);
    chk("midrst_memdata", 32'(bus.MemData), 32'd0);
    chk("midrst_cpuhold", 32'(bus.CpuHold), 32'd0);
    chk("midrst_count",   32'(bus.Count),   32'd0);
    tick();
    ResetN = 1'b1;
    bus.RxData = 8'hA5; bus.RxValid = 1'b1;
    repeat (3) tick();
    chk("postrst_rxready", 32'(bus.RxReady), 32'd0);
    chk("postrst_cpuhold", 32'(bus.CpuHold), 32'd0);
    gap();

    // Recovery after re-issued Start
    pre.delete();
    pl = '{8'hDE, 8'hAD};
    run_frame(pre, pl, 8'h8B, 1'b0);
    chk("recover_count", 32'(bus.Count), 32'd2);

    repeat (3) tick();
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("dones_drained",  32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
